// File: rtl/pe_conv2_pkg.sv
// pe_conv2_pkg: shared widths for the conv2 PE and its multipliers
package pe_conv2_pkg;
  localparam int IFMAP_W = 8;
  localparam int WGT_W = 8;
  localparam int PSUM_W = 20;
  localparam int NUM_TAPS = 3;
  localparam int PROD_W = IFMAP_W + WGT_W + 1;
  localparam int SUM_W = PSUM_W + 2;
  localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'((1 << (PSUM_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(-(1 << (PSUM_W - 1)));
endpackage

// File: rtl/pe_unit_conv2_if.sv
// pe_unit_conv2_if: data and daisy-chain signals of one conv2 PE
interface pe_unit_conv2_if;
  import pe_conv2_pkg::*;
  logic en;
  logic [NUM_TAPS*WGT_W-1:0] filtr_in;
  logic [IFMAP_W-1:0] ifmap_shift_in;
  logic signed [PSUM_W-1:0] psum_in;
  logic [NUM_TAPS*WGT_W-1:0] filtr_out;
  logic [IFMAP_W-1:0] ifmap_shift_out;
  logic signed [PSUM_W-1:0] psum_out;
  modport master (
    output en, filtr_in, ifmap_shift_in, psum_in,
    input filtr_out, ifmap_shift_out, psum_out
  );
  modport slave (
    input en, filtr_in, ifmap_shift_in, psum_in,
    output filtr_out, ifmap_shift_out, psum_out
  );
endinterface

// File: rtl/pe_conv2_mult.sv
// pe_conv2_mult: registered unsigned-sample x signed-weight multiplier with CE
module pe_conv2_mult
  import pe_conv2_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic [IFMAP_W-1:0] a,
  input  logic signed [WGT_W-1:0] w,
  output logic signed [PROD_W-1:0] p
);
  always_ff @(posedge clk)
    if (!rst_n) p <= '0;
    else if (ce) p <= PROD_W'($signed({1'b0, a})) * PROD_W'(w);
endmodule

// File: rtl/pe_unit_conv2.sv
// pe_unit_conv2: 3-tap conv2 systolic PE; define PE_CONV2_SAT_EN for a saturating accumulator
module pe_unit_conv2
  import pe_conv2_pkg::*;
(
  input logic clk,
  input logic rst_n,
  pe_unit_conv2_if.slave bus
);
  logic [IFMAP_W-1:0] s [NUM_TAPS];
  logic signed [PROD_W-1:0] p [NUM_TAPS];
  logic signed [SUM_W-1:0] sum;
  logic signed [PSUM_W-1:0] nxt;
  genvar t;
  for (t = 0; t < NUM_TAPS; t++) begin : g_tap
    pe_conv2_mult u_mult (
      .clk(clk),
      .rst_n(rst_n),
      .ce(bus.en),
      .a(s[t]),
      .w(bus.filtr_in[t*WGT_W +: WGT_W]),
      .p(p[t])
    );
  end
  always_comb begin
    sum = SUM_W'(bus.psum_in);
    for (int i = 0; i < NUM_TAPS; i++) sum = sum + SUM_W'(p[i]);
  end
`ifdef PE_CONV2_SAT_EN
  assign nxt = sum > SUM_MAX ? PSUM_W'(SUM_MAX) : sum < SUM_MIN ? PSUM_W'(SUM_MIN) : PSUM_W'(sum);
`else
  assign nxt = PSUM_W'(sum);
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      s <= '{default: '0};
      bus.filtr_out <= '0;
      bus.psum_out <= '0;
    end else if (bus.en) begin
      s[0] <= bus.ifmap_shift_in;
      for (int i = 1; i < NUM_TAPS; i++) s[i] <= s[i-1];
      bus.filtr_out <= bus.filtr_in;
      bus.psum_out <= nxt;
    end
  assign bus.ifmap_shift_out = s[0];
endmodule

// File: tb/tb_pe_unit_conv2.sv
// tb_pe_unit_conv2: vector table, stall sequence and randomized model check for pe_unit_conv2
module tb_pe_unit_conv2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nvec = 0;
  int nfail = 0;
  pe_unit_conv2_if bus ();
  pe_unit_conv2 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

`ifdef PE_CONV2_SAT_EN
  localparam int OV_HI = 524287;
  localparam int OV_LO = -524288;
`else
  localparam int OV_HI = -523304;
  localparam int OV_LO = 508288;
`endif

  // Reference: history of accepted samples/weights indexed by enabled edge since reset.
  logic [7:0] xh [0:4095];
  logic [23:0] wh [0:4095];
  int n = 0;
  int e_ps = 0, e_sh = 0, e_f = 0;

  function automatic int model_psum(int pin);
    int s;
    logic [23:0] wv;
    logic [7:0] xv;
    s = pin;
    wv = (n - 1 >= 1) ? wh[n-1] : 24'd0;
    for (int t = 0; t < 3; t++) begin
      xv = (n - 2 - t >= 1) ? xh[n-2-t] : 8'd0;
      s = s + int'(xv) * int'($signed(wv[t*8 +: 8]));
    end
`ifdef PE_CONV2_SAT_EN
    if (s > 524287) s = 524287;
    if (s < -524288) s = -524288;
`else
    s = (s <<< 12) >>> 12;
`endif
    return s;
  endfunction

  task automatic step(input logic r, input logic e, input logic [23:0] w, input logic [7:0] x, input int pin);
    rst_n = r;
    bus.en = e;
    bus.filtr_in = w;
    bus.ifmap_shift_in = x;
    bus.psum_in = 20'(pin);
    @(posedge clk);
    if (!r) begin
      n = 0; e_ps = 0; e_sh = 0; e_f = 0;
    end else if (e) begin
      n++;
      xh[n] = x;
      wh[n] = w;
      e_sh = int'(x);
      e_f = int'(w);
      e_ps = model_psum(int'($signed(20'(pin))));
    end
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int ps, input int sh, input int f);
    chk({tag, "_psum"}, int'(bus.psum_out), ps);
    chk({tag, "_shift"}, int'(bus.ifmap_shift_out), sh);
    chk({tag, "_filtr"}, int'(bus.filtr_out), f);
  endtask

  typedef struct {
    logic en;
    logic [23:0] w;
    logic [7:0] x;
    int pin;
    int e_ps;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic [23:0] w, logic [7:0] x, int pin, int e_ps);
    vec_t v;
    v.en = 1'b1; v.w = w; v.x = x; v.pin = pin; v.e_ps = e_ps;
    return v;
  endfunction

  initial begin
    bus.en = 1'b0;
    bus.filtr_in = '0;
    bus.ifmap_shift_in = '0;
    bus.psum_in = '0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 24'($urandom), 8'($urandom), int'($urandom));
      chk_all($sformatf("rst%0d", i), 0, 0, 0);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 24'd0, 8'd0, 0);
      chk_all($sformatf("post_rst%0d", i), 0, 0, 0);
    end

    tbl.push_back(mk(24'h030201, 8'd5, 0, 0));
    tbl.push_back(mk(24'h030201, 8'd0, 0, 0));
    tbl.push_back(mk(24'h030201, 8'd0, 0, 5));
    tbl.push_back(mk(24'h030201, 8'd0, 0, 10));
    tbl.push_back(mk(24'h030201, 8'd0, 0, 15));
    tbl.push_back(mk(24'h030201, 8'd0, 0, 0));
    tbl.push_back(mk(24'h030201, 8'd0, 1000, 1000));
    tbl.push_back(mk(24'h030201, 8'd7, 1000, 1000));
    tbl.push_back(mk(24'h030201, 8'd0, 0, 0));
    tbl.push_back(mk(24'h030201, 8'd0, 0, 7));
    tbl.push_back(mk(24'h030201, 8'd0, 0, 14));
    tbl.push_back(mk(24'h030201, 8'd0, 0, 21));
    tbl.push_back(mk(24'h030201, 8'd0, 0, 0));
    tbl.push_back(mk(24'h808080, 8'd255, 0, 0));
    tbl.push_back(mk(24'h808080, 8'd255, 0, 0));
    tbl.push_back(mk(24'h808080, 8'd255, 0, -32640));
    tbl.push_back(mk(24'h808080, 8'd255, 0, -65280));
    tbl.push_back(mk(24'h808080, 8'd255, 0, -97920));
    tbl.push_back(mk(24'h808080, 8'd255, 0, -97920));
    tbl.push_back(mk(24'h000008, 8'd125, 0, -97920));
    tbl.push_back(mk(24'h000008, 8'd125, 0, 2040));
    tbl.push_back(mk(24'h000008, 8'd125, 0, 1000));
    tbl.push_back(mk(24'h000008, 8'd125, 32'h7FFF0, OV_HI));
    tbl.push_back(mk(24'h000008, 8'd125, 32'h7FFF0, OV_HI));
    tbl.push_back(mk(24'h000080, 8'd125, -524288, -523288));
    tbl.push_back(mk(24'h000080, 8'd125, -524288, OV_LO));
    foreach (tbl[i]) begin
      step(1'b1, tbl[i].en, tbl[i].w, tbl[i].x, tbl[i].pin);
      chk_all($sformatf("tbl%0d", i), tbl[i].e_ps, int'(tbl[i].x), int'(tbl[i].w));
    end

    step(1'b0, 1'b1, 24'd0, 8'd0, 0);
    chk_all("stall_rst", 0, 0, 0);
    step(1'b1, 1'b1, 24'h030201, 8'd5, 0);
    step(1'b1, 1'b1, 24'h030201, 8'd0, 0);
    step(1'b1, 1'b1, 24'h030201, 8'd0, 0);
    chk_all("stall_pre", 5, 0, 24'h030201);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 24'($urandom), 8'($urandom), int'($urandom));
      chk_all($sformatf("stall%0d", i), 5, 0, 24'h030201);
    end
    step(1'b1, 1'b1, 24'h030201, 8'd0, 0);
    chk_all("resume0", 10, 0, 24'h030201);
    step(1'b1, 1'b1, 24'h030201, 8'd0, 0);
    chk_all("resume1", 15, 0, 24'h030201);
    step(1'b1, 1'b1, 24'h030201, 8'd0, 0);
    chk_all("resume2", 0, 0, 24'h030201);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) >= 3, $urandom_range(0, 9) >= 2,
           24'($urandom), 8'($urandom), int'($signed(20'($urandom))));
      chk_all($sformatf("rnd%0d", i), e_ps, e_sh, e_f);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
